// File: rtl/key_highlight_ctrl.sv
// Held-key tracker with minimum highlight time and per-frame snapshot.
// Ports: Clk/Reset_n, frame_start, ev_* handshake, query_*, snapshot outs.
module key_highlight_ctrl #(
  parameter int NUM_KEYS    = 14,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [3:0]          ev_key,
  input  logic                ev_on,
  input  logic [3:0]          query_key,
  output logic                query_active,
  output logic [NUM_KEYS-1:0] active_mask,
  output logic [3:0]          last_key,
  output logic                bad_key_err
);

  localparam logic [3:0] KMAX      = 4'(NUM_KEYS);
  localparam logic [2:0] HOLD_INIT = 3'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AGE  = 2'd1,
    SNAP = 2'd2
  } state_t;

  state_t state_q;

  logic [NUM_KEYS-1:0]      live_q, live_d;
  logic [NUM_KEYS-1:0]      pend_q, pend_d;
  logic [NUM_KEYS-1:0][2:0] hold_q, hold_d;
  logic [3:0]               last_on_q, last_on_d;
  logic                     bad_q, bad_d;
  logic [NUM_KEYS-1:0]      mask_q;
  logic [3:0]               last_key_q;
  logic [3:0]               snap_last;

  logic       accept;
  logic       key_ok;
  logic [3:0] ev_idx;
  logic       q_ok;

  // Gated by Reset_n so the source never sees ready during reset.
  assign ev_ready = Reset_n & (state_q == IDLE) & ~frame_start;
  assign accept   = ev_valid & ev_ready;
  assign key_ok   = (ev_key != 4'd0) && (ev_key <= KMAX);
  assign ev_idx   = ev_key - 4'd1;

  always_comb begin
    live_d    = live_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    last_on_d = last_on_q;
    bad_d     = bad_q;
    if (state_q == AGE) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (hold_q[k] != 3'd0)
          hold_d[k] = hold_q[k] - 3'd1;
        // A deferred release lands on the frame its hold expires.
        if (pend_q[k] && hold_d[k] == 3'd0) begin
          live_d[k] = 1'b0;
          pend_d[k] = 1'b0;
        end
      end
    end
    if (accept) begin
      if (!key_ok) begin
        bad_d = 1'b1;
      end else if (ev_on) begin
        live_d[ev_idx] = 1'b1;
        pend_d[ev_idx] = 1'b0;
        hold_d[ev_idx] = HOLD_INIT;
        last_on_d      = ev_key;
      end else if (live_q[ev_idx]) begin
        if (hold_q[ev_idx] == 3'd0)
          live_d[ev_idx] = 1'b0;
        else
          pend_d[ev_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    snap_last = 4'd0;
    if (last_on_q != 4'd0 && last_on_q <= KMAX)
      if (live_q[last_on_q - 4'd1])
        snap_last = last_on_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      live_q     <= '0;
      pend_q     <= '0;
      hold_q     <= '0;
      last_on_q  <= 4'd0;
      bad_q      <= 1'b0;
      mask_q     <= '0;
      last_key_q <= 4'd0;
    end else begin
      live_q    <= live_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      last_on_q <= last_on_d;
      bad_q     <= bad_d;
      unique case (state_q)
        IDLE: if (frame_start) state_q <= AGE;
        AGE:  state_q <= SNAP;
        SNAP: begin
          state_q    <= IDLE;
          mask_q     <= live_q;
          last_key_q <= snap_last;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_ok = (query_key != 4'd0) && (query_key <= KMAX);
  assign query_active = q_ok ? mask_q[query_key - 4'd1] : 1'b0;

  assign active_mask = mask_q;
  assign last_key    = last_key_q;
  assign bad_key_err = bad_q;

endmodule

// File: tb/tb_key_highlight_ctrl.sv
// Bench for key_highlight_ctrl: directed plan plus random frames
// checked against a press/age reference model.
module tb_key_highlight_ctrl;

  localparam int NK = 14;
  localparam int HF = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          ev_valid = 1'b0;
  logic          ev_on = 1'b0;
  logic [3:0]    ev_key = 4'd0;
  logic [3:0]    query_key = 4'd0;
  logic          ev_ready;
  logic          query_active;
  logic [NK-1:0] active_mask;
  logic [3:0]    last_key;
  logic          bad_key_err;

  key_highlight_ctrl #(.NUM_KEYS(NK), .HOLD_FRAMES(HF)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_start(frame_start),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_key(ev_key),
    .ev_on(ev_on),
    .query_key(query_key),
    .query_active(query_active),
    .active_mask(active_mask),
    .last_key(last_key),
    .bad_key_err(bad_key_err)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Model: a key is shown if the player still holds it or fewer
  // than HF frames have aged since its latest press.
  bit            m_pressed [1:NK];
  int            m_age     [1:NK];
  int            m_last_on;
  bit            m_bad;
  logic [NK-1:0] m_mask;
  logic [3:0]    m_lastkey;

  function automatic bit m_active(input int k);
    return m_pressed[k] || (m_age[k] < HF);
  endfunction

  task automatic m_reset();
    for (int k = 1; k <= NK; k++) begin
      m_pressed[k] = 1'b0;
      m_age[k] = HF;
    end
    m_last_on = 0;
    m_bad = 1'b0;
    m_mask = '0;
    m_lastkey = 4'd0;
  endtask

  task automatic m_event(input int key, input bit on);
    if (key >= 1 && key <= NK) begin
      if (on) begin
        m_pressed[key] = 1'b1;
        m_age[key] = 0;
        m_last_on = key;
      end else begin
        m_pressed[key] = 1'b0;
      end
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic m_frame();
    for (int k = 1; k <= NK; k++)
      if (m_age[k] < HF) m_age[k]++;
    for (int k = 1; k <= NK; k++)
      m_mask[k-1] = m_active(k);
    if (m_last_on != 0 && m_active(m_last_on))
      m_lastkey = 4'(m_last_on);
    else
      m_lastkey = 4'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int key, input bit on);
    int n;
    ev_valid = 1'b1;
    ev_key = 4'(key);
    ev_on = on;
    n = 0;
    while (!ev_ready && n < 20) begin
      step();
      n++;
    end
    if (!ev_ready) begin
      chk("ev_ready_wait", 32'(ev_ready), 32'd1);
    end else begin
      step();
      m_event(key, on);
    end
    ev_valid = 1'b0;
  endtask

  task automatic chk_snap(input string tag);
    chk({tag, "_mask"}, 32'(active_mask), 32'(m_mask));
    chk({tag, "_last"}, 32'(last_key), 32'(m_lastkey));
    chk({tag, "_bad"}, 32'(bad_key_err), 32'(m_bad));
  endtask

  task automatic frame(input string tag);
    logic [NK-1:0] old;
    old = m_mask;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk({tag, "_age_rdy"}, 32'(ev_ready), 32'd0);
    chk({tag, "_age_hold"}, 32'(active_mask), 32'(old));
    step();
    step();
    m_frame();
    chk_snap(tag);
  endtask

  task automatic chk_query(input int k);
    logic exp;
    query_key = 4'(k);
    #1;
    exp = (k >= 1 && k <= NK) ? m_mask[k-1] : 1'b0;
    chk("query", 32'(query_active), 32'(exp));
  endtask

  initial begin
    int nev;
    m_reset();

    // 1: reset, idle frames
    #12;
    chk("rst_rdy", 32'(ev_ready), 32'd0);
    chk("rst_mask", 32'(active_mask), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    chk("idle_rdy", 32'(ev_ready), 32'd1);
    for (int i = 0; i < 3; i++) frame("t1");
    chk("t1_rdy", 32'(ev_ready), 32'd1);

    // 2: key 5 on
    send(5, 1'b1);
    frame("t2");
    chk("t2_mask_lit", 32'(active_mask), 32'h0010);
    chk("t2_last_lit", 32'(last_key), 32'd5);
    chk_query(5);
    chk("t2_q5_lit", 32'(query_active), 32'd1);
    chk_query(0);
    chk("t2_q0_lit", 32'(query_active), 32'd0);

    // 3: short tap of key 3 still shows for HF-1 snapshots
    send(3, 1'b1);
    send(3, 1'b0);
    for (int i = 1; i <= HF; i++) begin
      frame("t3");
      chk("t3_bit2", 32'(active_mask[2]), (i < HF) ? 32'd1 : 32'd0);
    end
    chk("t3_last_lit", 32'(last_key), 32'd0);

    // 4: event raised together with frame_start
    frame_start = 1'b1;
    ev_valid = 1'b1;
    ev_key = 4'd7;
    ev_on = 1'b1;
    #1;
    chk("t4_fs_rdy", 32'(ev_ready), 32'd0);
    step();
    frame_start = 1'b0;
    chk("t4_age_rdy", 32'(ev_ready), 32'd0);
    step();
    chk("t4_snap_rdy", 32'(ev_ready), 32'd0);
    step();
    m_frame();
    chk_snap("t4_pre");
    chk("t4_idle_rdy", 32'(ev_ready), 32'd1);
    step();
    m_event(7, 1'b1);
    ev_valid = 1'b0;
    frame("t4");
    chk("t4_bit6", 32'(active_mask[6]), 32'd1);

    // 5: invalid keys
    send(15, 1'b1);
    send(0, 1'b0);
    chk("t5_bad_lit", 32'(bad_key_err), 32'd1);
    chk("t5_mask", 32'(active_mask), 32'(m_mask));
    frame("t5a");
    frame("t5b");
    chk("t5_sticky", 32'(bad_key_err), 32'd1);

    // random traffic
    for (int f = 0; f < 40; f++) begin
      nev = $urandom_range(0, 3);
      for (int e = 0; e < nev; e++)
        send(($urandom_range(0, 19) == 0) ? 15 : $urandom_range(1, NK),
             1'($urandom_range(0, 1)));
      frame("rnd");
      chk_query($urandom_range(0, 15));
    end

    // 6: reset mid-frame
    send(1, 1'b1);
    send(14, 1'b1);
    frame("t6a");
    chk("t6_both", 32'(active_mask & 14'h2001), 32'h2001);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    Reset_n = 1'b0;
    #1;
    m_reset();
    chk("t6_rst_mask", 32'(active_mask), 32'd0);
    chk("t6_rst_last", 32'(last_key), 32'd0);
    chk("t6_rst_rdy", 32'(ev_ready), 32'd0);
    chk("t6_rst_bad", 32'(bad_key_err), 32'd0);
    #2;
    Reset_n = 1'b1;
    step();
    send(14, 1'b1);
    chk("t6_pre_snap", 32'(active_mask), 32'd0);
    frame("t6b");
    chk("t6_mask_lit", 32'(active_mask), 32'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_highlight_ctrl.md
Name: key_highlight_ctrl

Overview:
- Tracks which on-screen piano keys (1..14) are held, from note-on/note-off events sent by the keyboard decoder.
- Enforces a minimum highlight time in frames, so very short presses still show on screen.
- Publishes a per-frame snapshot that stays stable for the whole frame. The color mapper queries it per pixel region for key highlight and the note-letter sprite.
- Sits between the keyboard/event logic and the color mapper in the VGA path.

Parameters:
- NUM_KEYS, 14, number of drawable keys; key indices are 1..NUM_KEYS.
- HOLD_FRAMES, 4, minimum number of frames a key stays highlighted after note-on (1..7).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- ev_valid  in  1  event present.
- ev_ready  out  1  event accepted when ev_valid & ev_ready are both high on a rising Clk edge.
- ev_key  in  4  key index of the event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- query_key  in  4  key index of the region under the current pixel; 0 = none.
- query_active  out  1  snapshot state of query_key (combinational).
- active_mask  out  NUM_KEYS  registered snapshot; bit k-1 corresponds to key k.
- last_key  out  4  most recent note-on key that is active in the snapshot, else 0.
- bad_key_err  out  1  sticky; set by an accepted event with ev_key==0 or ev_key>NUM_KEYS.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - live, pending_off, hold counters, active_mask, last_key, bad_key_err all cleared to 0.
  - FSM goes to IDLE; ev_ready is 0 while Reset_n is low.
- Reset mid-frame clears the snapshot immediately; no key is highlighted until the next SNAP.
- FSM states: IDLE, AGE, SNAP.
  - IDLE: on frame_start -> AGE.
  - AGE (1 cycle) -> SNAP.
  - SNAP (1 cycle) -> IDLE.
  - frame_start pulses seen in AGE or SNAP are ignored.
- ev_ready = (state==IDLE) & ~frame_start. Events are never accepted in the frame_start cycle, AGE or SNAP. The source holds the event until ready.
- Note-on, key k valid:
  - live[k]=1, hold[k]=HOLD_FRAMES, pending_off[k]=0.
  - last_on register = k.
  - Re-press of an already-active key restarts the hold.
- Note-off, key k valid:
  - If hold[k]==0: live[k]=0 immediately.
  - Otherwise pending_off[k]=1; live stays 1.
  - Note-off of an inactive key has no effect.
- Invalid key: the event is accepted (handshake completes), state is unchanged, bad_key_err=1 until reset.
- AGE, applied to every key in parallel:
  - If hold>0, hold decrements.
  - If pending_off is set and the new hold is 0, clear live and pending_off in this cycle.
- SNAP:
  - active_mask <= live.
  - last_key <= last_on if live[last_on]==1, else 0.
- Latency:
  - An event accepted in frame N appears in active_mask one cycle after the SNAP that follows the next frame_start.
  - A release is visible no earlier than HOLD_FRAMES frame_starts after the press.
- Snapshot stability: active_mask and last_key change only on the SNAP edge.
- query_active = active_mask[query_key-1] for query_key in 1..NUM_KEYS, else 0. Purely combinational; no added latency.
- Widths: hold counters are 3 bits; last_on is 4 bits.

Test Plan:
1. Reset, then no events; pulse frame_start 3 times -> active_mask=0, last_key=0, ev_ready=1 in IDLE, bad_key_err=0.
2. Note-on key 5 then frame_start -> after SNAP active_mask=0x0010, last_key=5. Set query_key=5 -> query_active=1; query_key=0 -> query_active=0.
3. Note-on key 3 immediately followed by note-off key 3 (HOLD_FRAMES=4) -> bit 2 set for snapshots 1..3 and clear in snapshot 4; last_key=0 once bit 2 clears.
4. Assert ev_valid in the same cycle as frame_start -> ev_ready=0 for that cycle, AGE and SNAP. The event is accepted in the first IDLE cycle after SNAP and shows in the following frame's snapshot.
5. Event ev_key=15, then ev_key=0 -> both accepted, bad_key_err=1, active_mask unchanged. bad_key_err stays 1 through further frames until Reset_n is pulsed low.
6. Keys 1 and 14 on, then Reset_n pulsed low mid-frame -> active_mask=0 and last_key=0 asynchronously. A new note-on of key 14 gives active_mask=0x2000 after the next SNAP.
